// File: rtl/mux_8x1_rr_if.sv
// Stream bundle for the 8-to-1 round-robin merger: eight valid/ready input
// channels plus one registered output stream tagged with its source channel.
interface mux_8x1_rr_if #(
  parameter int WIDTH = 8
);
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_8x1_rr.sv
// 8-to-1 round-robin stream merger; out_sel carries the source channel so a demux can route it back.
// Note: in_ready is a combinational function of in_valid (same cycle) through the priority tree.
module mux_8x1_rr #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  mux_8x1_rr_if.slave  bus
);

  logic [2:0]       ptr;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [2:0]       out_sel_q;

  logic             load;
  logic [15:0]      valid_dbl;
  logic [7:0]       rot;
  logic [3:0]       l1_any;
  logic [3:0]       l1_idx;
  logic [1:0]       l2_any;
  logic [1:0][1:0]  l2_idx;
  logic             any_valid;
  logic [2:0]       offset;
  logic [2:0]       grant;

  assign load = !out_valid_q || bus.out_ready;

  // Rotate requests so position 0 is ptr, then find the first set bit with a
  // three-level tree of 2:1 stages; the lower half always wins a tie.
  always_comb begin
    valid_dbl = {bus.in_valid, bus.in_valid};
    rot       = valid_dbl[ptr +: 8];
    l1_any    = '0;
    l1_idx    = '0;
    l2_any    = '0;
    l2_idx    = '0;
    for (int k = 0; k < 4; k++) begin
      l1_any[k] = rot[2*k] | rot[2*k+1];
      l1_idx[k] = !rot[2*k];
    end
    for (int k = 0; k < 2; k++) begin
      l2_any[k] = l1_any[2*k] | l1_any[2*k+1];
      l2_idx[k] = l1_any[2*k] ? {1'b0, l1_idx[2*k]} : {1'b1, l1_idx[2*k+1]};
    end
    any_valid = l2_any[0] | l2_any[1];
    offset    = l2_any[0] ? {1'b0, l2_idx[0]} : {1'b1, l2_idx[1]};
    grant     = ptr + offset;
  end

  assign bus.in_ready = (!rst && load && any_valid) ? (8'h01 << grant) : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 3'd0;
      ptr         <= 3'd0;
    end else if (load) begin
      if (any_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data[grant*WIDTH +: WIDTH];
        out_sel_q   <= grant;
        ptr         <= grant + 3'd1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_8x1_rr.sv
// Directed bench for mux_8x1_rr: reset, rotation, backpressure, wrap-around
// and mid-operation reset, with hand-computed expectations.
module tb_mux_8x1_rr;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  logic [7:0] chan_data [8];
  int total;
  int bad;

  mux_8x1_rr_if #(.WIDTH(WIDTH)) bus ();

  mux_8x1_rr #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs just after the falling edge, then let combinational ready settle.
  task automatic applyStimulus(input logic r, input logic [7:0] valid, input logic ready);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = valid;
    bus.out_ready = ready;
    for (int i = 0; i < 8; i++) bus.in_data[i*WIDTH +: WIDTH] = chan_data[i];
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 8; i++) chan_data[i] = 8'h10 + 8'(i);
    rst           = 1'b1;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    bus.in_data   = '0;

    // Reset held for two cycles with every channel requesting
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 8'hFF, 1'b1);
      checkOutput("rst_ready", 32'(bus.in_ready), 32'h00);
      checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_sel", 32'(bus.out_sel), 32'd0);
    end

    // Full contention: grants 0..7,0,1,2,3 back-to-back
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 8'hFF, 1'b1);
      checkOutput("rr_ready", 32'(bus.in_ready), 32'h01 << (k % 8));
      checkOutput("rr_valid", 32'(bus.out_valid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        checkOutput("rr_sel", 32'(bus.out_sel), 32'((k - 1) % 8));
        checkOutput("rr_data", 32'(bus.out_data), 32'h10 + 32'((k - 1) % 8));
      end
    end

    // Backpressure: channel 3 word held for three cycles
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'hFF, 1'b0);
      checkOutput("bp_ready", 32'(bus.in_ready), 32'h00);
      checkOutput("bp_sel", 32'(bus.out_sel), 32'd3);
      checkOutput("bp_data", 32'(bus.out_data), 32'h13);
      checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    applyStimulus(1'b0, 8'hFF, 1'b1);
    checkOutput("bp_release_ready", 32'(bus.in_ready), 32'h10);
    checkOutput("bp_release_sel", 32'(bus.out_sel), 32'd3);

    // Single channel 5 with distinctive data (ptr is now 5)
    chan_data[5] = 8'hA5;
    applyStimulus(1'b0, 8'h20, 1'b1);
    checkOutput("bp_next_sel", 32'(bus.out_sel), 32'd4);
    checkOutput("bp_next_data", 32'(bus.out_data), 32'h14);
    checkOutput("single_ready", 32'(bus.in_ready), 32'h20);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("single_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("single_sel", 32'(bus.out_sel), 32'd5);
    checkOutput("single_data", 32'(bus.out_data), 32'hA5);
    checkOutput("idle_ready", 32'(bus.in_ready), 32'h00);
    // Output empties but sel/data hold; ptr=6 makes channel 6 beat channel 0
    applyStimulus(1'b0, 8'h41, 1'b1);
    checkOutput("idle_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("idle_sel_hold", 32'(bus.out_sel), 32'd5);
    checkOutput("idle_data_hold", 32'(bus.out_data), 32'hA5);
    checkOutput("ptr6_ready", 32'(bus.in_ready), 32'h40);

    // Wrap-around: ptr=7 with channels 7 and 2 requesting
    applyStimulus(1'b0, 8'h84, 1'b1);
    checkOutput("ptr6_sel", 32'(bus.out_sel), 32'd6);
    checkOutput("wrap7_ready", 32'(bus.in_ready), 32'h80);
    applyStimulus(1'b0, 8'h04, 1'b1);
    checkOutput("wrap7_sel", 32'(bus.out_sel), 32'd7);
    checkOutput("wrap7_data", 32'(bus.out_data), 32'h17);
    checkOutput("wrap2_ready", 32'(bus.in_ready), 32'h04);
    // ptr=3: channel 3 must beat channel 0
    applyStimulus(1'b0, 8'h09, 1'b1);
    checkOutput("wrap2_sel", 32'(bus.out_sel), 32'd2);
    checkOutput("ptr3_ready", 32'(bus.in_ready), 32'h08);

    // Reset mid-operation while a word is held
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("mid_held_sel", 32'(bus.out_sel), 32'd3);
    checkOutput("mid_held_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("mid_rst_ready", 32'(bus.in_ready), 32'h00);
    applyStimulus(1'b0, 8'h81, 1'b1);
    checkOutput("mid_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_sel", 32'(bus.out_sel), 32'd0);
    checkOutput("mid_data", 32'(bus.out_data), 32'h00);
    checkOutput("mid_ptr0_ready", 32'(bus.in_ready), 32'h01);
    applyStimulus(1'b0, 8'h80, 1'b1);
    checkOutput("mid_first_sel", 32'(bus.out_sel), 32'd0);
    checkOutput("mid_first_data", 32'(bus.out_data), 32'h10);
    checkOutput("mid_second_ready", 32'(bus.in_ready), 32'h80);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("mid_second_sel", 32'(bus.out_sel), 32'd7);
    checkOutput("mid_second_valid", 32'(bus.out_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_8x1_rr.md
Name: mux_8x1_rr

Overview:
- 8-to-1 stream merger with round-robin arbitration. It collects eight independent valid/ready channels into one registered output stream.
- It is the converse of the 1x8 demux: each output word carries its source channel index (out_sel), so a downstream demux_1x8 can route the word back using that index as its select.
- It sits between per-channel producers and a shared serial path or resource.

Parameters:
WIDTH, 8, data bits per channel.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
in_valid  input  8  per-channel valid; bit i belongs to channel i.
in_data  input  8*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
in_ready  output  8  per-channel ready; at most one bit is high in any cycle.
out_valid  output  1  output word valid (registered).
out_data  output  WIDTH  output word (registered).
out_sel  output  3  source channel index of out_data (registered).
out_ready  input  1  downstream ready.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
  - Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready=0 while rst=1.
- Transfer rules:
  - A transfer occurs on any edge where valid&ready are both high.
  - A producer must hold in_data[i] stable while in_valid[i]=1 and in_ready[i]=0.
  - in_valid may not be withdrawn before the transfer completes.
- load = !out_valid | out_ready, i.e. the output register is empty or is being drained this cycle.
- Arbitration (combinational):
  - grant is the first i with in_valid[i]=1, searching ptr, ptr+1, ..., ptr+7, mod 8.
  - in_ready[i] = load & (grant==i) & in_valid[i].
  - This creates a combinational path from in_valid to in_ready; the path is permitted and must be documented in the block header.
- Clock edge with load=1 and any in_valid:
  - out_data <= granted channel's data; out_sel <= grant; out_valid <= 1.
  - ptr <= grant+1, with 3-bit wrap, so 7 -> 0.
- Clock edge with load=1 and no in_valid: out_valid <= 0. out_data, out_sel and ptr hold.
- Clock edge with load=0 (out_valid=1, out_ready=0): all registers hold. out_data and out_sel must remain bit-stable; all in_ready=0.
- Latency and throughput:
  - Input accept to out_valid is 1 cycle.
  - Full throughput is one word per cycle when out_ready=1 continuously.
  - Drain and refill in the same cycle is back-to-back, with no bubble.
- Fairness:
  - Once a channel is granted, it has the lowest priority next time.
  - A continuously asserted channel waits at most 7 transfers before it is granted.
- Reset mid-operation: any held output word is discarded (out_valid=0) and ptr returns to 0. Producers re-present their data.
- Structure:
  - The priority search is implemented as a tree of 2:1 select stages, three levels, mirroring the demux tree.
  - The select path is purely combinational; the only state is the output register and ptr.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_sel=0, in_ready=8'h00 throughout; first grant after release is channel 0.
- Single channel: in_valid=8'h20, channel 5 data=8'hA5, out_ready=1 -> in_ready=8'h20 for one cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=5; ptr=6.
- Full contention: in_valid=8'hFF held, channel i data=8'h10+i, out_ready=1 -> out_sel sequence 0,1,...,7,0 on consecutive cycles; out_data 8'h10..8'h17; no bubbles.
- Backpressure: while out_valid=1 with out_sel=3, out_data=8'h13, drop out_ready for 3 cycles -> out_data and out_sel stable and in_ready=0 each cycle; raise out_ready -> channel 4 is accepted the same cycle.
- Wrap-around: ptr=7, in_valid=8'h84 -> channel 7 granted first, then channel 2; ptr ends at 3.
- Reset mid-operation: out_valid=1 with out_ready=0, assert rst for 1 cycle -> out_valid=0, ptr=0; then in_valid=8'h81 -> channel 0 is granted before channel 7.
